// File: rtl/muse_pid_trigger.sv
// -----------------------------------------------------------------------------
// muse_pid_trigger
//
// Trigger builder that sits after the per-channel PID fine-time stages.
// Electron/Muon/Pion match flags from NCH channels are OR-collected into one
// mask per species over a programmable coincidence window. The highest-priority
// species (E > M > P) that meets its multiplicity is prescaled. If it is
// accepted, a one-cycle TrigOut pulse with a species code is issued, followed
// by a programmable deadtime.
//
// Ports
//   clk       50 MHz system clock
//   rst       asynchronous, active-high reset
//   Electron  [NCH] per-channel electron match pulses
//   Muon      [NCH] per-channel muon match pulses
//   Pion      [NCH] per-channel pion match pulses
//   Veto      synchronous external veto
//   TrigOut   one-cycle trigger pulse
//   TrigType  01=electron, 10=muon, 11=pion while TrigOut=1, else 00
//   Busy      high whenever the FSM is not idle
//   DataOut   local-bus read data (zero unless Read and address hit)
//   DataIn    local-bus write data
//   Address   local-bus address
//   Read      local-bus read strobe
//   Write     local-bus write strobe
//
// Register map (offset from BASE)
//   0 CTRL   [2:0] enable E/M/P, [3] scaler clear (write-only pulse),
//            [11:8] WIN, [23:16] DEAD
//   1 MULT   [4:0] E, [12:8] M, [20:16] P
//   2 PSC    [7:0] E, [15:8] M, [23:16] P
//   3..5     SCAL_E / SCAL_M / SCAL_P saturating accepted-trigger counters
// -----------------------------------------------------------------------------
module muse_pid_trigger #(
    parameter int unsigned NCH  = 16,
    parameter logic [7:0]  BASE = 8'hC0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   Electron,
    input  logic [NCH-1:0]   Muon,
    input  logic [NCH-1:0]   Pion,
    input  logic             Veto,
    output logic             TrigOut,
    output logic [1:0]       TrigType,
    output logic             Busy,
    output logic [31:0]      DataOut,
    input  logic [31:0]      DataIn,
    input  logic [7:0]       Address,
    input  logic             Read,
    input  logic             Write
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        EVAL   = 2'd2,
        DEAD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [7:0] popcnt(input logic [NCH-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < NCH; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A programmed zero window or multiplicity behaves as one.
    function automatic logic [3:0] nz_win(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    function automatic logic [4:0] nz_mult(input logic [4:0] v);
        return (v == 5'd0) ? 5'd1 : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [7:0]     dcnt_q, dcnt_d;
    logic [NCH-1:0] m_e_q, m_e_d, m_m_q, m_m_d, m_p_q, m_p_d;

    // Shadow copies taken at window start so bus writes never disturb
    // an event already in flight.
    logic [2:0]     sh_en_q, sh_en_d;
    logic [4:0]     sh_mult_e_q, sh_mult_e_d, sh_mult_m_q, sh_mult_m_d;
    logic [4:0]     sh_mult_p_q, sh_mult_p_d;
    logic [7:0]     sh_psc_e_q, sh_psc_e_d, sh_psc_m_q, sh_psc_m_d;
    logic [7:0]     sh_psc_p_q, sh_psc_p_d;

    logic [7:0]     pcnt_e_q, pcnt_e_d, pcnt_m_q, pcnt_m_d, pcnt_p_q, pcnt_p_d;
    logic           trig_q, trig_d;
    logic [1:0]     ttype_q, ttype_d;
    logic           inc_e, inc_m, inc_p;

    // Configuration registers
    logic [2:0]     en_q, en_d;
    logic [3:0]     win_q, win_d;
    logic [7:0]     dead_q, dead_d;
    logic [4:0]     mult_e_q, mult_e_d, mult_m_q, mult_m_d, mult_p_q, mult_p_d;
    logic [7:0]     psc_e_q, psc_e_d, psc_m_q, psc_m_d, psc_p_q, psc_p_d;
    logic           scal_clr;

    logic [31:0]    scal_e_q, scal_e_d, scal_m_q, scal_m_d, scal_p_q, scal_p_d;

    // ------------------------------------------------------------------
    // Local-bus decode. Subtracting BASE first makes the hit test a
    // single compare and keeps it correct even if BASE+5 would wrap.
    // ------------------------------------------------------------------
    logic [7:0] off;
    logic       hit;
    logic [7:0] unused_din;

    assign off        = Address - BASE;
    assign hit        = (off < 8'd6);
    assign unused_din = DataIn[31:24];

    always_comb begin
        en_d     = en_q;
        win_d    = win_q;
        dead_d   = dead_q;
        mult_e_d = mult_e_q;
        mult_m_d = mult_m_q;
        mult_p_d = mult_p_q;
        psc_e_d  = psc_e_q;
        psc_m_d  = psc_m_q;
        psc_p_d  = psc_p_q;
        scal_clr = 1'b0;
        if (Write && hit) begin
            case (off[2:0])
                3'd0: begin
                    en_d     = DataIn[2:0];
                    scal_clr = DataIn[3];
                    win_d    = DataIn[11:8];
                    dead_d   = DataIn[23:16];
                end
                3'd1: begin
                    mult_e_d = DataIn[4:0];
                    mult_m_d = DataIn[12:8];
                    mult_p_d = DataIn[20:16];
                end
                3'd2: begin
                    psc_e_d = DataIn[7:0];
                    psc_m_d = DataIn[15:8];
                    psc_p_d = DataIn[23:16];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        DataOut = '0;
        if (Read && hit) begin
            case (off[2:0])
                3'd0:    DataOut = {8'd0, dead_q, 4'd0, win_q, 5'd0, en_q};
                3'd1:    DataOut = {11'd0, mult_p_q, 3'd0, mult_m_q, 3'd0, mult_e_q};
                3'd2:    DataOut = {8'd0, psc_p_q, psc_m_q, psc_e_q};
                3'd3:    DataOut = scal_e_q;
                3'd4:    DataOut = scal_m_q;
                3'd5:    DataOut = scal_p_q;
                default: DataOut = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Trigger FSM next-state logic
    // ------------------------------------------------------------------
    logic [NCH-1:0] fe_live, fm_live, fp_live;
    logic [NCH-1:0] fe_sh, fm_sh, fp_sh;
    logic           start;
    logic           qual_e, qual_m, qual_p;
    logic [3:0]     win_eff;

    assign fe_live = Electron & {NCH{en_q[0]}};
    assign fm_live = Muon     & {NCH{en_q[1]}};
    assign fp_live = Pion     & {NCH{en_q[2]}};
    assign fe_sh   = Electron & {NCH{sh_en_q[0]}};
    assign fm_sh   = Muon     & {NCH{sh_en_q[1]}};
    assign fp_sh   = Pion     & {NCH{sh_en_q[2]}};
    assign start   = !Veto && ((|fe_live) || (|fm_live) || (|fp_live));
    assign win_eff = nz_win(win_q);

    assign qual_e = sh_en_q[0] && (popcnt(m_e_q) >= {3'd0, sh_mult_e_q});
    assign qual_m = sh_en_q[1] && (popcnt(m_m_q) >= {3'd0, sh_mult_m_q});
    assign qual_p = sh_en_q[2] && (popcnt(m_p_q) >= {3'd0, sh_mult_p_q});

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        dcnt_d      = dcnt_q;
        m_e_d       = m_e_q;
        m_m_d       = m_m_q;
        m_p_d       = m_p_q;
        sh_en_d     = sh_en_q;
        sh_mult_e_d = sh_mult_e_q;
        sh_mult_m_d = sh_mult_m_q;
        sh_mult_p_d = sh_mult_p_q;
        sh_psc_e_d  = sh_psc_e_q;
        sh_psc_m_d  = sh_psc_m_q;
        sh_psc_p_d  = sh_psc_p_q;
        pcnt_e_d    = pcnt_e_q;
        pcnt_m_d    = pcnt_m_q;
        pcnt_p_d    = pcnt_p_q;
        trig_d      = 1'b0;
        ttype_d     = 2'b00;
        inc_e       = 1'b0;
        inc_m       = 1'b0;
        inc_p       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // The start cycle already counts as window cycle 1.
                    m_e_d       = fe_live;
                    m_m_d       = fm_live;
                    m_p_d       = fp_live;
                    sh_en_d     = en_q;
                    sh_mult_e_d = nz_mult(mult_e_q);
                    sh_mult_m_d = nz_mult(mult_m_q);
                    sh_mult_p_d = nz_mult(mult_p_q);
                    sh_psc_e_d  = psc_e_q;
                    sh_psc_m_d  = psc_m_q;
                    sh_psc_p_d  = psc_p_q;
                    wcnt_d      = win_eff - 4'd1;
                    state_d     = (win_eff == 4'd1) ? EVAL : WINDOW;
                end
            end

            WINDOW: begin
                if (Veto) begin
                    m_e_d   = '0;
                    m_m_d   = '0;
                    m_p_d   = '0;
                    state_d = IDLE;
                end else begin
                    m_e_d  = m_e_q | fe_sh;
                    m_m_d  = m_m_q | fm_sh;
                    m_p_d  = m_p_q | fp_sh;
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d = EVAL;
                    end
                end
            end

            EVAL: begin
                // Only the highest-priority qualifying species consults
                // its prescaler; a reject there does not fall through.
                state_d = IDLE;
                m_e_d   = '0;
                m_m_d   = '0;
                m_p_d   = '0;
                if (qual_e) begin
                    if (pcnt_e_q == 8'd0) begin
                        pcnt_e_d = sh_psc_e_q;
                        trig_d   = 1'b1;
                        ttype_d  = 2'b01;
                        inc_e    = 1'b1;
                        dcnt_d   = dead_q;
                        state_d  = DEAD;
                    end else begin
                        pcnt_e_d = pcnt_e_q - 8'd1;
                    end
                end else if (qual_m) begin
                    if (pcnt_m_q == 8'd0) begin
                        pcnt_m_d = sh_psc_m_q;
                        trig_d   = 1'b1;
                        ttype_d  = 2'b10;
                        inc_m    = 1'b1;
                        dcnt_d   = dead_q;
                        state_d  = DEAD;
                    end else begin
                        pcnt_m_d = pcnt_m_q - 8'd1;
                    end
                end else if (qual_p) begin
                    if (pcnt_p_q == 8'd0) begin
                        pcnt_p_d = sh_psc_p_q;
                        trig_d   = 1'b1;
                        ttype_d  = 2'b11;
                        inc_p    = 1'b1;
                        dcnt_d   = dead_q;
                        state_d  = DEAD;
                    end else begin
                        pcnt_p_d = pcnt_p_q - 8'd1;
                    end
                end
            end

            DEAD: begin
                if (dcnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a coincident increment.
    assign scal_e_d = scal_clr ? 32'd0 : (inc_e ? sat_inc(scal_e_q) : scal_e_q);
    assign scal_m_d = scal_clr ? 32'd0 : (inc_m ? sat_inc(scal_m_q) : scal_m_q);
    assign scal_p_d = scal_clr ? 32'd0 : (inc_p ? sat_inc(scal_p_q) : scal_p_q);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            dcnt_q      <= '0;
            m_e_q       <= '0;
            m_m_q       <= '0;
            m_p_q       <= '0;
            sh_en_q     <= '0;
            sh_mult_e_q <= 5'd1;
            sh_mult_m_q <= 5'd1;
            sh_mult_p_q <= 5'd1;
            sh_psc_e_q  <= '0;
            sh_psc_m_q  <= '0;
            sh_psc_p_q  <= '0;
            pcnt_e_q    <= '0;
            pcnt_m_q    <= '0;
            pcnt_p_q    <= '0;
            trig_q      <= 1'b0;
            ttype_q     <= 2'b00;
            en_q        <= 3'b111;
            win_q       <= 4'd4;
            dead_q      <= 8'd10;
            mult_e_q    <= 5'd1;
            mult_m_q    <= 5'd1;
            mult_p_q    <= 5'd1;
            psc_e_q     <= '0;
            psc_m_q     <= '0;
            psc_p_q     <= '0;
            scal_e_q    <= '0;
            scal_m_q    <= '0;
            scal_p_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            dcnt_q      <= dcnt_d;
            m_e_q       <= m_e_d;
            m_m_q       <= m_m_d;
            m_p_q       <= m_p_d;
            sh_en_q     <= sh_en_d;
            sh_mult_e_q <= sh_mult_e_d;
            sh_mult_m_q <= sh_mult_m_d;
            sh_mult_p_q <= sh_mult_p_d;
            sh_psc_e_q  <= sh_psc_e_d;
            sh_psc_m_q  <= sh_psc_m_d;
            sh_psc_p_q  <= sh_psc_p_d;
            pcnt_e_q    <= pcnt_e_d;
            pcnt_m_q    <= pcnt_m_d;
            pcnt_p_q    <= pcnt_p_d;
            trig_q      <= trig_d;
            ttype_q     <= ttype_d;
            en_q        <= en_d;
            win_q       <= win_d;
            dead_q      <= dead_d;
            mult_e_q    <= mult_e_d;
            mult_m_q    <= mult_m_d;
            mult_p_q    <= mult_p_d;
            psc_e_q     <= psc_e_d;
            psc_m_q     <= psc_m_d;
            psc_p_q     <= psc_p_d;
            scal_e_q    <= scal_e_d;
            scal_m_q    <= scal_m_d;
            scal_p_q    <= scal_p_d;
        end
    end

    assign TrigOut  = trig_q;
    assign TrigType = ttype_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_muse_pid_trigger.sv
module tb_muse_pid_trigger;

    localparam int unsigned NCH  = 16;
    localparam logic [7:0]  BASE = 8'hC0;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  Electron, Muon, Pion;
    logic            Veto;
    logic            TrigOut;
    logic [1:0]      TrigType;
    logic            Busy;
    logic [31:0]     DataOut, DataIn;
    logic [7:0]      Address;
    logic            Read, Write;

    int checks = 0;
    int errors = 0;

    muse_pid_trigger #(.NCH(NCH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .Electron(Electron), .Muon(Muon), .Pion(Pion), .Veto(Veto),
        .TrigOut(TrigOut), .TrigType(TrigType), .Busy(Busy),
        .DataOut(DataOut), .DataIn(DataIn), .Address(Address),
        .Read(Read), .Write(Write)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Advance to 1 ns after the next rising edge (start of the next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d);
        Address = BASE + o;
        DataIn  = d;
        Write   = 1'b1;
        tick();
        Write   = 1'b0;
        Address = '0;
        DataIn  = '0;
    endtask

    task automatic rd(input logic [7:0] o, output logic [31:0] d);
        Address = BASE + o;
        Read    = 1'b1;
        #1;
        d       = DataOut;
        Read    = 1'b0;
        Address = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (TrigOut !== 1'b0) begin errors++; $display("FAIL rst_trig got %b exp 0", TrigOut); end
        checks++; if (TrigType !== 2'b00) begin errors++; $display("FAIL rst_type got %b exp 00", TrigType); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", Busy); end
        rd(8'd0, d);
        checks++; if (d !== 32'h000A_0407) begin errors++; $display("FAIL rst_ctrl got %h exp 000a0407", d); end
        rd(8'd1, d);
        checks++; if (d !== 32'h0001_0101) begin errors++; $display("FAIL rst_mult got %h exp 00010101", d); end
        rd(8'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_psc got %h exp 0", d); end
        rd(8'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_scal_e got %h exp 0", d); end
        rd(8'd6, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL miss_addr got %h exp 0", d); end
        Address = BASE; #1;
        checks++; if (DataOut !== 32'h0) begin errors++; $display("FAIL no_read got %h exp 0", DataOut); end
        Address = '0;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        tick();
        Electron[3] = 1'b1;
        tick();
        Electron = '0;
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (TrigOut !== (c == 5) || TrigType !== ((c == 5) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL basic_trig c=%0d got %b/%b", c, TrigOut, TrigType);
            end
            checks++;
            if (Busy !== (c <= 15)) begin
                errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, Busy, (c <= 15));
            end
            tick();
        end
        rd(8'd3, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL basic_scal_e got %h exp 1", d); end
    endtask

    task automatic test_coincidence();
        logic [31:0] d;
        wr(8'd1, 32'h0001_0201);
        wr(8'd0, 32'h000A_0307);
        // flags two cycles apart: inside WIN=3
        Muon[0] = 1'b1;
        tick();
        Muon = '0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) Muon[7] = 1'b1;
            checks++;
            if (TrigOut !== (c == 4) || TrigType !== ((c == 4) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL coinc_in c=%0d got %b/%b", c, TrigOut, TrigType);
            end
            tick();
            Muon = '0;
        end
        repeat (12) tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL coinc_idle got %b exp 0", Busy); end
        // flags three cycles apart: second lands in EVAL and is dropped
        Muon[0] = 1'b1;
        tick();
        Muon = '0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) Muon[7] = 1'b1;
            checks++;
            if (TrigOut !== 1'b0) begin errors++; $display("FAIL coinc_out c=%0d got %b exp 0", c, TrigOut); end
            if (c >= 4) begin
                checks++;
                if (Busy !== 1'b0) begin errors++; $display("FAIL coinc_drop c=%0d busy %b exp 0", c, Busy); end
            end
            tick();
            Muon = '0;
        end
        rd(8'd4, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL coinc_scal_m got %h exp 1", d); end
        wr(8'd1, 32'h0001_0101);
        wr(8'd0, 32'h000A_0407);
    endtask

    task automatic test_priority();
        logic [31:0] d;
        Electron[1] = 1'b1;
        Pion[2]     = 1'b1;
        tick();
        Electron = '0;
        Pion     = '0;
        repeat (4) tick();
        checks++;
        if (TrigOut !== 1'b1 || TrigType !== 2'b01) begin
            errors++; $display("FAIL prio_type got %b/%b exp 1/01", TrigOut, TrigType);
        end
        repeat (14) tick();
        rd(8'd5, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_scal_p got %h exp 0", d); end
        rd(8'd3, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL prio_scal_e got %h exp 2", d); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic        seen;
        logic [1:0]  ty;
        wr(8'd2, 32'h0002_0000);
        for (int ev = 1; ev <= 6; ev++) begin
            seen = 1'b0;
            ty   = 2'b00;
            Pion[5] = 1'b1;
            tick();
            Pion = '0;
            for (int c = 0; c < 18; c++) begin
                if (TrigOut) begin seen = 1'b1; ty = TrigType; end
                tick();
            end
            checks++;
            if (seen !== (ev == 1 || ev == 4)) begin
                errors++; $display("FAIL psc_event ev=%0d got %b exp %b", ev, seen, (ev == 1 || ev == 4));
            end
            if (ev == 4) begin
                checks++;
                if (ty !== 2'b11) begin errors++; $display("FAIL psc_type got %b exp 11", ty); end
            end
        end
        rd(8'd5, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL psc_scal_p got %h exp 2", d); end
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        // WIN=0 acts as 1, DEAD=0 returns to idle right after the pulse
        wr(8'd0, 32'h0000_0007);
        Electron[0] = 1'b1;
        tick();
        Electron = '0;
        checks++;
        if (TrigOut !== 1'b0 || Busy !== 1'b1) begin
            errors++; $display("FAIL bnd_c1 got %b/%b exp 0/1", TrigOut, Busy);
        end
        tick();
        checks++; if (TrigOut !== 1'b1) begin errors++; $display("FAIL bnd_trig got %b exp 1", TrigOut); end
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL bnd_idle got %b exp 0", Busy); end
        wr(8'd0, 32'h000A_0407);
        rd(8'd3, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL bnd_scal_e got %h exp 3", d); end
    endtask

    task automatic test_veto();
        logic [31:0] d;
        Electron[0] = 1'b1;
        tick();
        Electron = '0;
        Veto = 1'b1;
        tick();
        Veto = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL veto_idle got %b exp 0", Busy); end
        Electron[0] = 1'b1;
        tick();
        Electron = '0;
        for (int c = 3; c <= 8; c++) begin
            checks++;
            if (TrigOut !== (c == 7)) begin errors++; $display("FAIL veto_restart c=%0d got %b", c, TrigOut); end
            tick();
        end
        repeat (12) tick();
        rd(8'd3, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL veto_scal_e got %h exp 4", d); end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        force dut.scal_e_q = 32'hFFFF_FFFF;
        #1;
        release dut.scal_e_q;
        rd(8'd3, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_pre got %h exp ffffffff", d); end
        tick();
        Electron[2] = 1'b1;
        tick();
        Electron = '0;
        repeat (18) tick();
        rd(8'd3, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp ffffffff", d); end
    endtask

    task automatic test_clear_and_reset();
        logic [31:0] d;
        wr(8'd1, 32'h0003_0101);
        Electron[0] = 1'b1;
        tick();
        Electron = '0;
        repeat (3) tick();
        // cycle 4 is EVAL: clear lands on the same edge as the increment
        Address = BASE;
        DataIn  = 32'h000A_040F;
        Write   = 1'b1;
        tick();
        Write   = 1'b0;
        DataIn  = '0;
        checks++;
        if (TrigOut !== 1'b1 || TrigType !== 2'b01) begin
            errors++; $display("FAIL clr_trig got %b/%b exp 1/01", TrigOut, TrigType);
        end
        rd(8'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL clr_scal_e got %h exp 0", d); end
        rd(8'd5, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL clr_scal_p got %h exp 0", d); end
        rd(8'd0, d);
        checks++; if (d !== 32'h000A_0407) begin errors++; $display("FAIL clr_ctrl got %h exp 000a0407", d); end
        // asynchronous reset mid-deadtime
        rst = 1'b1;
        #1;
        checks++;
        if (TrigOut !== 1'b0 || Busy !== 1'b0 || TrigType !== 2'b00) begin
            errors++; $display("FAIL rst_async got %b/%b/%b exp 0/0/00", TrigOut, Busy, TrigType);
        end
        rd(8'd1, d);
        checks++; if (d !== 32'h0001_0101) begin errors++; $display("FAIL rst_mult2 got %h exp 00010101", d); end
        rd(8'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_psc2 got %h exp 0", d); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_after got %b exp 0", Busy); end
    endtask

    initial begin
        rst      = 1'b1;
        Electron = '0;
        Muon     = '0;
        Pion     = '0;
        Veto     = 1'b0;
        DataIn   = '0;
        Address  = '0;
        Read     = 1'b0;
        Write    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_coincidence();
        test_priority();
        test_prescale();
        test_boundary();
        test_veto();
        test_saturation();
        test_clear_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
